// File: rtl/fft_result_reader.sv
// fft_result_reader
// Captures one parallel frame of N complex FFT results and streams it out one
// sample per valid/ready handshake. All outputs are registered.
// Optional build macro: FFT_BITREV_EN. When it is defined, bins leave in
// bit-reversed index order. When it is undefined, bins leave in natural order.

module fft_result_reader #(
  parameter int N   = 16,
  parameter int MSB = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_valid,
  input  logic [N-1:0][MSB-1:0]     frame_in,
  output logic [MSB-1:0]            sample_out,
  output logic [$clog2(N)-1:0]      sample_addr,
  output logic                      sample_valid,
  input  logic                      sample_ready,
  output logic                      sample_last,
  output logic                      busy,
  output logic                      overflow
);

  localparam int             AW       = $clog2(N);
  localparam logic [AW-1:0]  LAST_IDX = AW'(N - 1);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t                    state;
  state_t                    state_next;
  logic [AW-1:0]             idx;
  logic [AW-1:0]             idx_next;
  logic [AW-1:0]             addr_next;
  logic [MSB-1:0]            data_next;
  logic                      capture;
  logic                      drop;
  logic                      handshake;
  logic [N-1:0][MSB-1:0]     frame_buf;

  // Map the stream position to the bin index that leaves at that position.
  function automatic logic [AW-1:0] ord(input logic [AW-1:0] i);
    logic [AW-1:0] r;
`ifdef FFT_BITREV_EN
    for (int b = 0; b < AW; b++) begin
      r[b] = i[AW-1-b];
    end
`else
    r = i;
`endif
    return r;
  endfunction

  // State and stream position register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Next state, next position, frame capture and drop decisions.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    capture    = 1'b0;
    drop       = 1'b0;
    handshake  = sample_valid & sample_ready;
    case (state)
      IDLE: begin
        if (frame_valid) begin
          capture    = 1'b1;
          idx_next   = '0;
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (handshake) begin
          if (idx == LAST_IDX) begin
            idx_next = '0;
            if (frame_valid) begin
              capture    = 1'b1;
              state_next = STREAM;
            end else begin
              state_next = IDLE;
            end
          end else begin
            idx_next = idx + 1'b1;
          end
        end
        if (frame_valid && !capture) begin
          drop = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  // Output data for the next cycle. A freshly captured frame is read straight
  // from the bus because the buffer only updates at the same edge.
  always_comb begin
    addr_next = ord(idx_next);
    data_next = capture ? frame_in[addr_next] : frame_buf[addr_next];
  end

  // Frame buffer. It is deliberately not reset, because only captured data is ever shown.
  always_ff @(posedge clk) begin
    if (!rst && capture) begin
      frame_buf <= frame_in;
    end
  end

  // Registered outputs. The outputs are derived from the next state, so they never depend combinationally on sample_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_out   <= '0;
      sample_addr  <= '0;
      sample_valid <= 1'b0;
      sample_last  <= 1'b0;
      busy         <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      sample_valid <= (state_next == STREAM);
      busy         <= (state_next == STREAM);
      sample_last  <= (state_next == STREAM) && (idx_next == LAST_IDX);
      sample_addr  <= (state_next == STREAM) ? addr_next : '0;
      sample_out   <= (state_next == STREAM) ? data_next : '0;
      overflow     <= overflow | drop;
    end
  end

endmodule

// File: tb/tb_fft_result_reader.sv
// tb_fft_result_reader
// Scoreboard bench for fft_result_reader (N=16, MSB=16). Build with or without
// FFT_BITREV_EN; the expected bin order follows the same macro.

module tb_fft_result_reader;

  localparam int N   = 16;
  localparam int MSB = 16;
  localparam int AW  = $clog2(N);

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  frame_valid;
  logic [N-1:0][MSB-1:0] frame_in;
  logic [MSB-1:0]        sample_out;
  logic [AW-1:0]         sample_addr;
  logic                  sample_valid;
  logic                  sample_ready;
  logic                  sample_last;
  logic                  busy;
  logic                  overflow;

  typedef struct packed {
    logic [AW-1:0]  addr;
    logic [MSB-1:0] data;
    logic           last;
  } exp_t;

  exp_t exp_q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   pop_count = 0;
  logic stalled_prev = 1'b0;
  logic [AW+MSB:0] held_word = '0;

  fft_result_reader #(.N(N), .MSB(MSB)) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_valid  (frame_valid),
    .frame_in     (frame_in),
    .sample_out   (sample_out),
    .sample_addr  (sample_addr),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample_last  (sample_last),
    .busy         (busy),
    .overflow     (overflow)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  // Expected stream position to bin mapping.
  function automatic logic [AW-1:0] tb_ord(input int i);
    logic [AW-1:0] v;
    logic [AW-1:0] r;
    v = AW'(i);
`ifdef FFT_BITREV_EN
    r = '0;
    for (int b = 0; b < AW; b++) begin
      r[AW-1-b] = v[b];
    end
`else
    r = v;
`endif
    return r;
  endfunction

  // Word for bin k of a frame identified by seed. Seed 0 gives {k, 8'h80+k}.
  function automatic logic [MSB-1:0] make_word(input int seed, input int k);
    logic [7:0] re;
    logic [7:0] im;
    re = 8'(seed + k);
    im = 8'(8'h80 + k + seed * 5);
    return {re, im};
  endfunction

  // Count one comparison and report it if it mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, expv);
    end
  endtask

  // Drive a frame and hold frame_valid for hold_cycles edges. When the frame
  // should be accepted, queue its expected samples in stream order.
  task automatic applyStimulus(input int seed, input int hold_cycles, input bit accept);
    for (int k = 0; k < N; k++) begin
      frame_in[k] = make_word(seed, k);
    end
    if (accept) begin
      for (int i = 0; i < N; i++) begin
        exp_q.push_back('{addr: tb_ord(i), data: make_word(seed, int'(tb_ord(i))), last: (i == N - 1)});
      end
    end
    frame_valid = 1'b1;
    repeat (hold_cycles) @(posedge clk);
    #1;
    frame_valid = 1'b0;
  endtask

  // Wait until the scoreboard empties, with an optional 0101 ready pattern.
  task automatic wait_drain(input int max_cycles, input bit toggle, output int cycles);
    cycles = 0;
    while (exp_q.size() != 0 && cycles < max_cycles) begin
      @(posedge clk);
      #1;
      cycles++;
      if (toggle) sample_ready = ~sample_ready;
    end
    if (exp_q.size() != 0) begin
      checkOutput("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  // Wait until n more samples have been accepted, or give up after a bounded number of cycles.
  task automatic wait_pops(input int n);
    int target;
    int guard;
    target = pop_count + n;
    guard  = 0;
    while (pop_count < target && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checkOutput("pop_timeout", (pop_count >= target) ? 1 : 0, 1);
  endtask

  // Monitor: score each accepted sample and confirm stalled samples stay stable.
  always @(negedge clk) begin
    if (rst) begin
      stalled_prev <= 1'b0;
    end else begin
      if (stalled_prev && sample_valid) begin
        checkOutput("hold_stable", 32'({sample_addr, sample_out, sample_last}), 32'(held_word));
      end
      if (sample_valid && sample_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_sample", 1, 0);
        end else begin
          checkOutput("addr", 32'(sample_addr), 32'(exp_q[0].addr));
          checkOutput("data", 32'(sample_out), 32'(exp_q[0].data));
          checkOutput("last", 32'(sample_last), 32'(exp_q[0].last));
          void'(exp_q.pop_front());
        end
        pop_count <= pop_count + 1;
      end
      stalled_prev <= sample_valid && !sample_ready;
      held_word    <= {sample_addr, sample_out, sample_last};
    end
  end

  // Watchdog that stops a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence.
  initial begin
    int cycles;
    int guard;
    rst          = 1'b1;
    frame_valid  = 1'b0;
    sample_ready = 1'b0;
    frame_in     = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid", 32'(sample_valid), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_overflow", 32'(overflow), 0);
    checkOutput("rst_addr", 32'(sample_addr), 0);
    checkOutput("rst_out", 32'(sample_out), 0);
    checkOutput("rst_last", 32'(sample_last), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Test 1: ready held high, so one sample per cycle.
    $display("[TB] test 1: full-rate stream");
    sample_ready = 1'b1;
    applyStimulus(0, 1, 1'b1);
    checkOutput("t1_latency_valid", 32'(sample_valid), 1);
    checkOutput("t1_latency_busy", 32'(busy), 1);
    wait_drain(100, 1'b0, cycles);
    checkOutput("t1_cycles", cycles, N);
    checkOutput("t1_valid_after", 32'(sample_valid), 0);
    checkOutput("t1_busy_after", 32'(busy), 0);

    // Test 2: ready toggles 0101..., so every sample is held one cycle.
    $display("[TB] test 2: ready toggling");
    sample_ready = 1'b0;
    applyStimulus(0, 1, 1'b1);
    wait_drain(200, 1'b1, cycles);
    checkOutput("t2_cycles", cycles, 2 * N);
    sample_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t2_valid_after", 32'(sample_valid), 0);

    // Test 3: frame B arrives in the same cycle as frame A's last handshake.
    $display("[TB] test 3: back-to-back frames");
    applyStimulus(3, 1, 1'b1);
    guard = 0;
    while (!(sample_valid && sample_last) && guard < 60) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checkOutput("t3_reach_last", 32'(sample_valid && sample_last), 1);
    applyStimulus(7, 1, 1'b1);
    checkOutput("t3_no_bubble_valid", 32'(sample_valid), 1);
    checkOutput("t3_no_bubble_addr", 32'(sample_addr), 32'(tb_ord(0)));
    wait_drain(100, 1'b0, cycles);
    checkOutput("t3_overflow", 32'(overflow), 0);

    // Test 4: a frame arrives mid-stream and is dropped.
    $display("[TB] test 4: dropped frame");
    applyStimulus(11, 1, 1'b1);
    wait_pops(5);
    applyStimulus(40, 1, 1'b0);
    checkOutput("t4_overflow_set", 32'(overflow), 1);
    for (int k = 0; k < N; k++) begin
      frame_in[k] = '0;
    end
    wait_drain(100, 1'b0, cycles);
    @(posedge clk);
    #1;
    checkOutput("t4_overflow_sticky", 32'(overflow), 1);
    checkOutput("t4_idle_valid", 32'(sample_valid), 0);

    // Test 5: reset in the middle of a stream, then a fresh frame.
    $display("[TB] test 5: reset mid-stream");
    applyStimulus(20, 1, 1'b1);
    wait_pops(7);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    checkOutput("t5_valid", 32'(sample_valid), 0);
    checkOutput("t5_busy", 32'(busy), 0);
    checkOutput("t5_overflow", 32'(overflow), 0);
    checkOutput("t5_addr", 32'(sample_addr), 0);
    checkOutput("t5_out", 32'(sample_out), 0);
    checkOutput("t5_last", 32'(sample_last), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(25, 1, 1'b1);
    checkOutput("t5_restart_valid", 32'(sample_valid), 1);
    checkOutput("t5_restart_addr", 32'(sample_addr), 0);
    wait_drain(100, 1'b0, cycles);

    // frame_valid held for two cycles in IDLE: only the first cycle captures.
    $display("[TB] test 7: frame_valid held two cycles");
    applyStimulus(30, 2, 1'b1);
    wait_drain(100, 1'b0, cycles);
    checkOutput("t7_overflow", 32'(overflow), 1);
    checkOutput("t7_pending", exp_q.size(), 0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
